seq_mult_hs: RTL and testbench



---
 rtl/seq_mult_hs.sv | 116 +++++++++++
 tb/tb_seq_mult_hs.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative shift-add multiplier, one multiplier bit per clock,
// with valid/ready handshakes on the operand and product sides. Signed
// operands are reduced to magnitudes up front and the sign is re-applied
// when the final product is loaded into c.
module seq_mult_hs #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     mcand_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     c_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [WIDTH-1:0]  magA_d;
    logic [WIDTH-1:0]  magB_d;
    logic [PW-1:0]     acc_d;
    logic [PW-1:0]     result_d;

    // Operand magnitudes, next partial sum, and the sign-corrected final product.
    always_comb begin
        magA_d   = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        magB_d   = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        result_d = neg_q ? (~acc_d + PW'(1)) : acc_d;
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            c_q         <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        mcand_q    <= {{WIDTH{1'b0}}, magA_d};
                        mplier_q   <= magB_d;
                        neg_q      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        c_q         <= result_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign c         = c_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: drives a 4-bit and an 8-bit seq_mult_hs instance with
// directed and random operations and compares against an arithmetic model.
module tb_seq_mult_hs;

    logic        clk = 1'b0;
    logic        rst;

    logic        inValid4, inReady4, signedMode4, outValid4, outReady4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  c4;

    logic        inValid8, inReady8, signedMode8, outValid8, outReady8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] c8;

    int numChecks = 0;
    int numFails  = 0;

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    seq_mult_hs #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(inValid4), .in_ready(inReady4),
        .a(a4), .b(b4), .signed_mode(signedMode4), .out_valid(outValid4),
        .out_ready(outReady4), .c(c4), .busy(busy4)
    );

    seq_mult_hs #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .signed_mode(signedMode8), .out_valid(outValid8),
        .out_ready(outReady8), .c(c8), .busy(busy8)
    );

    // Count a comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference product: interpret operands as integers, multiply, truncate.
    function automatic logic [63:0] refProduct(input int w, input logic [7:0] av,
                                               input logic [7:0] bv, input logic sm);
        longint x, y, p;
        x = longint'(av);
        y = longint'(bv);
        if (sm && av[w-1]) x = x - (longint'(1) << w);
        if (sm && bv[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        return 64'(p) & ((64'(1) << (2 * w)) - 64'(1));
    endfunction

    function automatic logic getOv(input bit sel);
        return sel ? outValid8 : outValid4;
    endfunction

    function automatic logic getIr(input bit sel);
        return sel ? inReady8 : inReady4;
    endfunction

    function automatic logic getBusy(input bit sel);
        return sel ? busy8 : busy4;
    endfunction

    function automatic logic [15:0] getC(input bit sel);
        return sel ? c8 : {8'h00, c4};
    endfunction

    task automatic setInputs(input bit sel, input logic valid, input logic [7:0] av,
                             input logic [7:0] bv, input logic sm);
        if (sel) begin
            inValid8 = valid; a8 = av; b8 = bv; signedMode8 = sm;
        end else begin
            inValid4 = valid; a4 = av[3:0]; b4 = bv[3:0]; signedMode4 = sm;
        end
    endtask

    task automatic setOutReady(input bit sel, input logic r);
        if (sel) outReady8 = r;
        else     outReady4 = r;
    endtask

    task automatic junkInputs(input bit sel);
        setInputs(sel, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // One full operation; called and returns at a negedge with the DUT idle.
    task automatic applyStimulus(input bit sel, input logic [7:0] avIn, input logic [7:0] bvIn,
                                 input logic sm, input int holdCycles);
        int          w;
        int          cycles;
        logic [7:0]  av, bv;
        logic [63:0] expected;
        w  = sel ? 8 : 4;
        av = sel ? avIn : (avIn & 8'h0F);
        bv = sel ? bvIn : (bvIn & 8'h0F);
        expected = refProduct(w, av, bv, sm);
        checkOutput("in_ready before accept", 64'(getIr(sel)), 64'(1));
        setInputs(sel, 1'b1, av, bv, sm);
        setOutReady(sel, 1'b0);
        @(posedge clk);
        @(negedge clk);
        junkInputs(sel);
        checkOutput("busy after accept", 64'(getBusy(sel)), 64'(1));
        checkOutput("in_ready low in CALC", 64'(getIr(sel)), 64'(0));
        cycles = 0;
        while (!getOv(sel) && cycles < 3 * w) begin
            @(posedge clk);
            @(negedge clk);
            junkInputs(sel);
            cycles++;
        end
        checkOutput("latency", 64'(cycles), 64'(w));
        checkOutput("product", 64'(getC(sel)), expected);
        for (int k = 0; k < holdCycles; k++) begin
            @(posedge clk);
            @(negedge clk);
            junkInputs(sel);
            checkOutput("out_valid held", 64'(getOv(sel)), 64'(1));
            checkOutput("c stable", 64'(getC(sel)), expected);
            checkOutput("in_ready low in DONE", 64'(getIr(sel)), 64'(0));
        end
        setInputs(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        setOutReady(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        setOutReady(sel, 1'b0);
        checkOutput("out_valid after handshake", 64'(getOv(sel)), 64'(0));
        checkOutput("in_ready after handshake", 64'(getIr(sel)), 64'(1));
        checkOutput("busy after handshake", 64'(getBusy(sel)), 64'(0));
        checkOutput("c retained", 64'(getC(sel)), expected);
    endtask

    // Reset arriving in the second CALC cycle must discard the operation.
    task automatic resetMidCalc();
        setInputs(1'b0, 1'b1, 8'h07, 8'h07, 1'b0);
        @(posedge clk);
        @(negedge clk);
        setInputs(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset mid-CALC out_valid", 64'(outValid4), 64'(0));
        checkOutput("reset mid-CALC in_ready", 64'(inReady4), 64'(1));
        checkOutput("reset mid-CALC busy", 64'(busy4), 64'(0));
        checkOutput("reset mid-CALC c", 64'(c4), 64'(0));
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        rst = 1'b1;
        setInputs(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        setInputs(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        outReady4 = 1'b0;
        outReady8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            checkOutput("reset in_ready", 64'(getIr(s[0])), 64'(1));
            checkOutput("reset out_valid", 64'(getOv(s[0])), 64'(0));
            checkOutput("reset busy", 64'(getBusy(s[0])), 64'(0));
            checkOutput("reset c", 64'(getC(s[0])), 64'(0));
        end

        applyStimulus(1'b0, 8'h05, 8'h05, 1'b0, 0);
        applyStimulus(1'b0, 8'h0F, 8'h0F, 1'b0, 0);
        applyStimulus(1'b0, 8'h08, 8'h08, 1'b1, 0);
        applyStimulus(1'b0, 8'h08, 8'h07, 1'b1, 0);
        applyStimulus(1'b0, 8'h0F, 8'h03, 1'b1, 0);
        applyStimulus(1'b0, 8'h00, 8'h0B, 1'b1, 0);
        applyStimulus(1'b0, 8'h03, 8'h06, 1'b0, 10);
        applyStimulus(1'b0, 8'h09, 8'h0D, 1'b0, 0);
        resetMidCalc();
        applyStimulus(1'b0, 8'h02, 8'h03, 1'b0, 0);
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1'b0, 8'($urandom), 8'($urandom), 1'($urandom),
                          int'($urandom_range(2, 0)));
        end

        applyStimulus(1'b1, 8'h80, 8'h80, 1'b1, 0);
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 0);
        applyStimulus(1'b1, 8'h80, 8'h7F, 1'b1, 3);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom),
                          int'($urandom_range(2, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
